// File: rtl/snoop_bus_arbiter_if.sv
// Snoop bus arbitration interface: request/done from the requesters,
// registered grant information back from the arbiter.
interface snoop_bus_arbiter_if #(
    parameter int NUM_CPUS = 4
);
    localparam int IDX_W = $clog2(NUM_CPUS);

    logic [NUM_CPUS-1:0] req;
    logic                done;
    logic [NUM_CPUS-1:0] gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                busy;
    logic                timeout;

    // Requester side: raises requests and signals transaction completion.
    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  busy,
        input  timeout
    );

    // Arbiter side: samples requests and drives the grant.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output busy,
        output timeout
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter with a one-cycle bus turnaround after each
// release and a hold limit that forcibly revokes a grant never ended by done.
module snoop_bus_arbiter #(
    parameter int NUM_CPUS = 4,
    parameter int MAX_HOLD = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    snoop_bus_arbiter_if.slave   bus
);
    localparam int IDX_W  = $clog2(NUM_CPUS);
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

    // Last hold count before the grant is revoked.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_TURN = 2'd2;

    logic [1:0]          state_q,    state_d;
    logic [NUM_CPUS-1:0] gnt_q,      gnt_d;
    logic [IDX_W-1:0]    gnt_idx_q,  gnt_idx_d;
    logic [IDX_W-1:0]    rr_ptr_q,   rr_ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                timeout_q,  timeout_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    cand;
    logic                release_now;

    // Find the first requester at or above rr_ptr, wrapping modulo NUM_CPUS.
    always_comb begin
        // NOTE: every variable gets a default before any branch so the
        // combinational block never infers a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            // NUM_CPUS is a power of two, so the index add wraps naturally.
            cand = rr_ptr_q + IDX_W'(i);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Release on done, or when the hold limit is reached; done has priority
    // for deciding whether the release counts as a timeout.
    assign release_now = bus.done || (hold_cnt_q == HOLD_LAST);

    // Next-state logic for the IDLE -> BUSY -> TURN -> IDLE cycle.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_BUSY;
                    gnt_d      = NUM_CPUS'(1) << pick_idx;
                    gnt_idx_d  = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    state_d    = ST_TURN;
                    gnt_d      = '0;
                    gnt_idx_d  = '0;
                    rr_ptr_d   = gnt_idx_q + IDX_W'(1);
                    hold_cnt_d = '0;
                    timeout_d  = !bus.done;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_TURN: begin
                // Bus turnaround: one dead cycle, done is ignored here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_d     = '0;
                gnt_idx_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.busy    = |gnt_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed self-checking bench for snoop_bus_arbiter (NUM_CPUS=4, MAX_HOLD=4).
module tb_snoop_bus_arbiter;
    localparam int NUM_CPUS = 4;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    logic mon_en = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    snoop_bus_arbiter_if #(.NUM_CPUS(NUM_CPUS)) bus ();

    snoop_bus_arbiter #(
        .NUM_CPUS(NUM_CPUS),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its hand-computed expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full output check after an edge.
    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                              input logic t);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        check({tag, ".gnt_idx"}, 32'(bus.gnt_idx), 32'(idx));
        check({tag, ".busy"}, 32'(bus.busy), 32'(g != 4'b0000));
        check({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
    endtask

    // Per-cycle structural checks on the grant outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] exp_idx;
            exp_idx = 2'd0;
            for (int b = 0; b < NUM_CPUS; b++) begin
                if (bus.gnt[b]) exp_idx = 2'(b);
            end
            check("mon.onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
            check("mon.busy", 32'(bus.busy), 32'(bus.gnt != 4'b0000));
            check("mon.gnt_idx", 32'(bus.gnt_idx), 32'(exp_idx));
        end
    end

    initial begin
        logic [3:0] rr_seq [5];
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000;
        rr_seq[4] = 4'b0001;

        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        step();
        step();
        expect_out("reset", 4'b0000, 2'd0, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Simple grant, held until done three edges later.
        bus.req = 4'b0100;
        step();
        expect_out("simple.grant", 4'b0100, 2'd2, 1'b0);
        step();
        step();
        expect_out("simple.hold", 4'b0100, 2'd2, 1'b0);
        bus.done = 1'b1;
        step();
        expect_out("simple.release", 4'b0000, 2'd0, 1'b0);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        step();
        expect_out("simple.turn", 4'b0000, 2'd0, 1'b0);

        // done in IDLE is ignored. rr_ptr is now 3.
        bus.done = 1'b1;
        step();
        expect_out("idle.done", 4'b0000, 2'd0, 1'b0);
        bus.done = 1'b0;

        // Wrap and skip: rr_ptr=3, req=0011 -> 0001; then rr_ptr=1 -> 0010.
        bus.req = 4'b0011;
        step();
        expect_out("wrap.first", 4'b0001, 2'd0, 1'b0);
        bus.done = 1'b1;
        step();
        check("wrap.release", 32'(bus.gnt), 32'h0);
        bus.done = 1'b0;
        step();
        check("wrap.turn", 32'(bus.gnt), 32'h0);
        step();
        expect_out("wrap.second", 4'b0010, 2'd1, 1'b0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        step();

        // Round robin from rr_ptr=0 with all four requesting.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rr.grant%0d", k), 32'(bus.gnt), 32'(rr_seq[k]));
            bus.done = 1'b1;
            step();
            check($sformatf("rr.gap_a%0d", k), 32'(bus.gnt), 32'h0);
            bus.done = 1'b0;
            if (k == 4) bus.req = 4'b0000;
            step();
            check($sformatf("rr.gap_b%0d", k), 32'(bus.gnt), 32'h0);
        end

        // Timeout: rr_ptr=1, req=0001, done low -> held 4 cycles then revoked.
        bus.req = 4'b0001;
        step();
        expect_out("to.grant", 4'b0001, 2'd0, 1'b0);
        for (int k = 1; k < MAX_HOLD; k++) begin
            step();
            expect_out($sformatf("to.hold%0d", k), 4'b0001, 2'd0, 1'b0);
        end
        step();
        expect_out("to.revoke", 4'b0000, 2'd0, 1'b1);
        step();
        expect_out("to.pulse_end", 4'b0000, 2'd0, 1'b0);

        // done coincides with the hold limit: done wins, no timeout.
        step();
        check("tod.grant", 32'(bus.gnt), 32'h1);
        step();
        step();
        step();
        bus.done = 1'b1;
        step();
        expect_out("tod.release", 4'b0000, 2'd0, 1'b0);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        step();
        check("tod.after", 32'(bus.timeout), 32'h0);

        // Granted requester drops req: grant held. rr_ptr is 1.
        bus.req = 4'b0010;
        step();
        expect_out("drop.grant", 4'b0010, 2'd1, 1'b0);
        bus.req = 4'b0000;
        step();
        check("drop.held", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0100;
        step();
        check("drop.other", 32'(bus.gnt), 32'h2);

        // Reset in BUSY clears outputs and rr_ptr.
        rst     = 1'b1;
        bus.req = 4'b0000;
        step();
        expect_out("rst.busy", 4'b0000, 2'd0, 1'b0);
        rst     = 1'b0;
        bus.req = 4'b1001;
        step();
        expect_out("rst.rrptr", 4'b0001, 2'd0, 1'b0);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        step();
        bus.req = 4'b1000;
        step();
        expect_out("rst.req1000", 4'b1000, 2'd3, 1'b0);

        // Reset during TURN.
        bus.done = 1'b1;
        step();
        rst      = 1'b1;
        bus.done = 1'b0;
        step();
        expect_out("rst.turn", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        step();

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
